sad_result_reorder: RTL and testbench

SAD_RESULT_REORDER -- requirements
Module: sad_result_reorder

---
 rtl/sad_pkg.sv | 19 +
 rtl/sad_result_reorder_if.sv | 25 ++
 rtl/sad_result_reorder.sv | 127 ++++++++++++
 tb/tb_sad_result_reorder.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sad_pkg.sv
// Shared types and defaults for the SAD result reorder buffer.
// Holds the FSM state enum, size defaults and the batch-size helper.
package sad_pkg;

    localparam int unsigned DEPTH_DEF  = 16;
    localparam int unsigned DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // A batch size of zero encodes a full batch of sixteen.
    function automatic logic [4:0] eff_num(input logic [4:0] n);
        return (n == 5'd0) ? 5'd16 : n;
    endfunction

endpackage

// File: rtl/sad_result_reorder_if.sv
// Result handshake bundle for the SAD reorder buffer.
// master: result source + sink ready; slave: the reorder buffer.
interface sad_result_reorder_if #(
    parameter int DATA_W = 16
);
    logic              in_valid;
    logic [4:0]        in_id;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic [3:0]        out_id;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    modport master (
        output in_valid, in_id, in_data, out_ready,
        input  in_ready, out_valid, out_id, out_data, out_last
    );

    modport slave (
        input  in_valid, in_id, in_data, out_ready,
        output in_ready, out_valid, out_id, out_data, out_last
    );
endinterface

// File: rtl/sad_result_reorder.sv
// Reorders out-of-order SAD results of a batch into index order.
// Ports: batch control, in_* accept side, out_* in-order side, status.
module sad_result_reorder
    import sad_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              batch_start,
    input  logic [4:0]        batch_num,
    input  logic              in_valid,
    input  logic [4:0]        in_id,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_id,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              batch_done,
    output logic              err_range,
    output logic              err_dup
);

    state_e            state_q, state_d;
    logic [4:0]        num_q, num_d;
    logic [DEPTH-1:0]  rcv_q, rcv_d;
    logic [DEPTH-1:0]  vld_q, vld_d;
    logic [3:0]        rd_ptr_q, rd_ptr_d;
    logic [4:0]        out_cnt_q, out_cnt_d;
    logic              err_range_q, err_range_d;
    logic              err_dup_q, err_dup_d;
    logic [DATA_W-1:0] slot_q [DEPTH];

    logic acc, bad_range, bad_dup, wr_en, hs;

    assign in_ready   = (state_q == S_RUN);
    assign busy       = (state_q != S_IDLE);
    assign batch_done = (state_q == S_DONE);
    assign err_range  = err_range_q;
    assign err_dup    = err_dup_q;

    assign out_valid = (state_q == S_RUN) && vld_q[rd_ptr_q];
    // Gate data/id so unreset slot contents never reach the outputs.
    assign out_id    = out_valid ? rd_ptr_q : 4'd0;
    assign out_data  = out_valid ? slot_q[rd_ptr_q] : '0;
    assign out_last  = out_valid && (out_cnt_q == num_q - 5'd1);

    assign acc       = in_valid && in_ready;
    assign bad_range = in_id[4] || (in_id >= num_q);
    // Received bits stay set after emission, so late repeats are dups too.
    assign bad_dup   = !bad_range && rcv_q[in_id[3:0]];
    assign wr_en     = acc && !bad_range && !bad_dup;
    assign hs        = out_valid && out_ready;

    always_comb begin
        state_d     = state_q;
        num_d       = num_q;
        rcv_d       = rcv_q;
        vld_d       = vld_q;
        rd_ptr_d    = rd_ptr_q;
        out_cnt_d   = out_cnt_q;
        err_range_d = err_range_q;
        err_dup_d   = err_dup_q;
        unique case (state_q)
            S_IDLE: begin
                if (batch_start) begin
                    state_d     = S_RUN;
                    num_d       = eff_num(batch_num);
                    rcv_d       = '0;
                    vld_d       = '0;
                    rd_ptr_d    = 4'd0;
                    out_cnt_d   = 5'd0;
                    err_range_d = 1'b0;
                    err_dup_d   = 1'b0;
                end
            end
            S_RUN: begin
                if (acc && bad_range) err_range_d = 1'b1;
                if (acc && bad_dup)   err_dup_d   = 1'b1;
                if (wr_en) begin
                    rcv_d[in_id[3:0]] = 1'b1;
                    vld_d[in_id[3:0]] = 1'b1;
                end
                // Write and read slots differ whenever both fire.
                if (hs) begin
                    vld_d[rd_ptr_q] = 1'b0;
                    rd_ptr_d        = rd_ptr_q + 4'd1;
                    out_cnt_d       = out_cnt_q + 5'd1;
                    if (out_last) state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            num_q       <= 5'd16;
            rcv_q       <= '0;
            vld_q       <= '0;
            rd_ptr_q    <= 4'd0;
            out_cnt_q   <= 5'd0;
            err_range_q <= 1'b0;
            err_dup_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            num_q       <= num_d;
            rcv_q       <= rcv_d;
            vld_q       <= vld_d;
            rd_ptr_q    <= rd_ptr_d;
            out_cnt_q   <= out_cnt_d;
            err_range_q <= err_range_d;
            err_dup_q   <= err_dup_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) slot_q[in_id[3:0]] <= in_data;
    end

endmodule

// File: tb/tb_sad_result_reorder.sv
// Scoreboard bench for sad_result_reorder.
// Directed cases plus randomized batches against a reorder model.
module tb_sad_result_reorder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       batch_start = 1'b0;
    logic [4:0] batch_num = 5'd0;
    logic       busy, batch_done, err_range, err_dup;

    sad_result_reorder_if #(.DATA_W(16)) bus ();

    always #5 clk = ~clk;

    sad_result_reorder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .batch_start(batch_start),
        .batch_num  (batch_num),
        .in_valid   (bus.in_valid),
        .in_id      (bus.in_id),
        .in_data    (bus.in_data),
        .in_ready   (bus.in_ready),
        .out_valid  (bus.out_valid),
        .out_ready  (bus.out_ready),
        .out_id     (bus.out_id),
        .out_data   (bus.out_data),
        .out_last   (bus.out_last),
        .busy       (busy),
        .batch_done (batch_done),
        .err_range  (err_range),
        .err_dup    (err_dup)
    );

    typedef struct {
        int id;
        int data;
        bit last;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: results arrive in any order, leave in index order.
    int mnum, nxt;
    bit got[32];
    int mdata[32];
    bit exp_rng, exp_dup;

    int rdy_mode = 0;
    int cyc = 0;
    int t0 = 0, tl = 0;
    int dchk = 0;
    bit stall_prev = 0;
    int sid, sdata;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic model_init(input int n);
        mnum = (n == 0) ? 16 : n;
        nxt = 0;
        exp_rng = 0;
        exp_dup = 0;
        for (int i = 0; i < 32; i++) got[i] = 0;
    endtask

    task automatic model_accept(input int id, input int d);
        if (id >= mnum) exp_rng = 1;
        else if (got[id]) exp_dup = 1;
        else begin
            got[id] = 1;
            mdata[id] = d;
        end
        while (nxt < mnum && got[nxt]) begin
            exp_q.push_back('{id: nxt, data: mdata[nxt], last: (nxt == mnum - 1)});
            nxt++;
        end
    endtask

    // Sink ready pattern: 0 always ready, 1 stalled, 2 random.
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: bus.out_ready = 1'b1;
                1: bus.out_ready = 1'b0;
                default: bus.out_ready = ($urandom % 3) != 0;
            endcase
        end
    end

    // Monitor: sampled on the falling edge, handshakes complete on the next rise.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            stall_prev = 0;
            dchk = 0;
        end else begin
            if (dchk == 1) begin
                chk("batch_done_pulse", batch_done, 1);
                dchk = 2;
            end else if (dchk == 2) begin
                chk("batch_done_end", batch_done, 0);
                dchk = 0;
            end
            if (bus.out_valid) begin
                if (stall_prev) begin
                    chk("hold_id", bus.out_id, sid);
                    chk("hold_data", bus.out_data, sdata);
                end
                if (bus.out_ready) begin
                    stall_prev = 0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL spurious_out actual id=%0d required none", bus.out_id);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("out_id", bus.out_id, e.id);
                        chk("out_data", bus.out_data, e.data);
                        chk("out_last", bus.out_last, e.last);
                        if (e.id == 0) t0 = cyc;
                        if (e.last) begin
                            tl = cyc;
                            dchk = 1;
                        end
                    end
                end else begin
                    stall_prev = 1;
                    sid = bus.out_id;
                    sdata = bus.out_data;
                end
            end else begin
                if (stall_prev) chk("hold_valid", bus.out_valid, 1);
                stall_prev = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input int n);
        batch_start = 1'b1;
        batch_num = n[4:0];
        tick();
        batch_start = 1'b0;
        model_init(n);
        chk("busy_start", busy, 1);
        chk("err_clear", {err_range, err_dup}, 0);
    endtask

    task automatic send(input int id, input int d);
        chk("in_ready", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.in_id = id[4:0];
        bus.in_data = d[15:0];
        tick();
        bus.in_valid = 1'b0;
        model_accept(id, d);
    endtask

    task automatic drain(input bit er, input bit ed);
        bit ok;
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            if (exp_q.size() == 0 && !busy) begin
                ok = 1;
                break;
            end
            tick();
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual left=%0d required 0", exp_q.size());
            exp_q.delete();
        end
        chk("err_range", err_range, er);
        chk("err_dup", err_dup, ed);
        chk("model_range", exp_rng, er);
        chk("model_dup", exp_dup, ed);
    endtask

    initial begin
        int perm[16];
        int n, en, j, tmp;
        bus.in_valid = 1'b0;
        bus.in_id = 5'd0;
        bus.in_data = 16'd0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outs", {bus.in_ready, bus.out_valid, bus.out_last, busy,
            batch_done, err_range, err_dup, bus.out_id, bus.out_data}, 0);
        rst_n = 1'b1;
        tick();

        // Four results out of order; a mid-batch start is ignored.
        rdy_mode = 0;
        tick();
        start(4);
        send(3, 'h30);
        batch_start = 1'b1;
        batch_num = 5'd1;
        tick();
        batch_start = 1'b0;
        send(1, 'h10);
        send(0, 'h00);
        send(2, 'h20);
        drain(0, 0);

        // Full batch in reverse: nothing until id 0, then a back-to-back burst.
        start(0);
        for (int id = 15; id >= 1; id--) send(id, $urandom % 65536);
        chk("no_early_out", bus.out_valid, 0);
        send(0, $urandom % 65536);
        drain(0, 0);
        chk("burst_len", tl - t0, 15);

        // Duplicate keeps the first value.
        start(2);
        send(1, 'h1234);
        send(1, 'hFFFF);
        send(0, 'h0055);
        drain(0, 1);

        // Out-of-range ids are dropped.
        start(3);
        send(5, 'h5555);
        send(0, 'h0a0a);
        send(16, 'h1616);
        send(2, 'h0c0c);
        send(1, 'h0b0b);
        drain(1, 0);

        // Output stall with a concurrent accept.
        rdy_mode = 1;
        tick();
        start(4);
        send(0, 'hA0);
        send(2, 'hA2);
        repeat (4) tick();
        chk("stall_valid", bus.out_valid, 1);
        chk("stall_id", bus.out_id, 0);
        chk("stall_data", bus.out_data, 'hA0);
        rdy_mode = 0;
        send(1, 'hA1);
        send(3, 'hA3);
        drain(0, 0);

        // Reset in the middle of a batch.
        start(4);
        send(0, 'h100);
        send(1, 'h101);
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrun_reset", {bus.in_ready, bus.out_valid, bus.out_last, busy,
            batch_done, err_range, err_dup, bus.out_id, bus.out_data}, 0);
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
        start(4);
        send(2, 'h202);
        send(0, 'h200);
        send(3, 'h203);
        send(1, 'h201);
        drain(0, 0);

        // Random batches, random order, random junk ids, random sink.
        rdy_mode = 2;
        for (int b = 0; b < 10; b++) begin
            n = $urandom % 16;
            en = (n == 0) ? 16 : n;
            for (int i = 0; i < 16; i++) perm[i] = i;
            for (int i = en - 1; i > 0; i--) begin
                j = $urandom_range(i, 0);
                tmp = perm[i];
                perm[i] = perm[j];
                perm[j] = tmp;
            end
            start(n);
            for (int i = 0; i < en; i++) begin
                if ($urandom % 5 == 0) send($urandom % 32, $urandom % 65536);
                send(perm[i], $urandom % 65536);
                repeat ($urandom % 3) tick();
            end
            drain(exp_rng, exp_dup);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
